// File: rtl/mult_add_128_pkg.sv
// Shared constants and types for the 128-lane multiply-accumulate responder.
// The saturation bounds and widths are also used by the fc controllers.
package mult_add_128_pkg;

  localparam int NLANE  = 128;          // lanes per vector, fixed by the interface
  localparam int LANE_W = 8;            // bits per lane
  localparam int RES_W  = 15;           // width of the returned result
  localparam int ACC_W  = 23;           // signed accumulator, holds any 128-lane sum
  localparam int SHIFT  = 7;            // activation scale: 0x80 == 1.0
  localparam int PROD_W = 2 * LANE_W;   // one signed lane product

  localparam logic [RES_W-1:0] SAT_POS = 15'h3FFF;
  localparam logic [RES_W-1:0] SAT_NEG = 15'h4000;

  // Saturation thresholds expressed in accumulator width for signed compares
  localparam logic signed [ACC_W-1:0] SAT_HI = ACC_W'(16383);
  localparam logic signed [ACC_W-1:0] SAT_LO = ACC_W'(-16384);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACC  = 2'd1,
    ST_OUT  = 2'd2
  } state_t;

  typedef struct packed {
    logic [RES_W-1:0] result;
    logic             overflow;
  } sat_t;

  // Clamp an already scaled sum into the signed 15-bit result range
  function automatic sat_t saturate(input logic signed [ACC_W-1:0] s);
    sat_t r;
    if (s > SAT_HI) begin
      r.result   = SAT_POS;
      r.overflow = 1'b1;
    end else if (s < SAT_LO) begin
      r.result   = SAT_NEG;
      r.overflow = 1'b1;
    end else begin
      r.result   = s[RES_W-1:0];
      r.overflow = 1'b0;
    end
    return r;
  endfunction

endpackage

// File: rtl/mult_add_128_mac_slice.sv
// Combinational LANES-wide signed x unsigned multiply followed by a balanced
// pairwise adder tree. Weights are signed bytes, activations unsigned bytes.
module mult_add_128_mac_slice
  import mult_add_128_pkg::*;
#(
  parameter int LANES = 16
) (
  input  logic [LANES*LANE_W-1:0] i_w,
  input  logic [LANES*LANE_W-1:0] i_x,
  output logic signed [ACC_W-1:0] o_sum
);

  logic signed [ACC_W-1:0] w_prod [LANES];
  logic signed [ACC_W-1:0] w_tree [LANES];

  genvar gi;
  generate
    for (gi = 0; gi < LANES; gi++) begin : g_lane
      logic signed [PROD_W-1:0] w_wext;
      logic signed [PROD_W-1:0] w_xext;
      logic signed [PROD_W-1:0] w_p;
      // Activation gets a zero top bit so it multiplies as a non-negative value
      assign w_wext = {{LANE_W{i_w[gi*LANE_W+LANE_W-1]}}, i_w[gi*LANE_W +: LANE_W]};
      assign w_xext = {{LANE_W{1'b0}}, i_x[gi*LANE_W +: LANE_W]};
      // Full product always fits in 16 signed bits (-32640..32385)
      assign w_p    = w_wext * w_xext;
      assign w_prod[gi] = {{(ACC_W-PROD_W){w_p[PROD_W-1]}}, w_p};
    end
  endgenerate

  // Balanced reduction: each pass halves the live width by summing neighbours
  always_comb begin
    for (int i = 0; i < LANES; i++) begin
      w_tree[i] = w_prod[i];
    end
    for (int width = LANES / 2; width >= 1; width = width / 2) begin
      for (int i = 0; i < width; i++) begin
        w_tree[i] = w_tree[2*i] + w_tree[2*i+1];
      end
    end
    o_sum = w_tree[0];
  end

endmodule

// File: rtl/mult_add_128.sv
// MultAdd responder: latches two 128-lane byte vectors, accumulates their dot
// product over NLANE/LANES beats, then scales and saturates to 15 bits.
module mult_add_128
  import mult_add_128_pkg::*;
#(
  parameter int LANES = 16
) (
  input  logic                      clk,
  input  logic                      iRst_n,
  input  logic                      ena,
  input  logic                      iStart,
  input  logic [NLANE*LANE_W-1:0]   iData1,
  input  logic [NLANE*LANE_W-1:0]   iData2,
  output logic                      oBusy,
  output logic                      oValid,
  output logic [RES_W-1:0]          oResult,
  output logic                      oOverflow
);

  localparam int NBEAT   = NLANE / LANES;
  localparam int SLICE_W = LANES * LANE_W;
  localparam int BEAT_W  = (NBEAT > 1) ? $clog2(NBEAT) : 1;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(NBEAT - 1);

  state_t                   r_state,    w_state_next;
  logic [BEAT_W-1:0]        r_beat,     w_beat_next;
  logic signed [ACC_W-1:0]  r_acc,      w_acc_next;
  logic [NLANE*LANE_W-1:0]  r_w,        w_w_next;
  logic [NLANE*LANE_W-1:0]  r_x,        w_x_next;
  logic                     r_busy,     w_busy_next;
  logic                     r_valid,    w_valid_next;
  logic [RES_W-1:0]         r_result,   w_result_next;
  logic                     r_overflow, w_overflow_next;

  logic [SLICE_W-1:0]       w_w_slices [NBEAT];
  logic [SLICE_W-1:0]       w_x_slices [NBEAT];
  logic [SLICE_W-1:0]       w_w_sel;
  logic [SLICE_W-1:0]       w_x_sel;
  logic signed [ACC_W-1:0]  w_partial;
  logic signed [ACC_W-1:0]  w_scaled;
  sat_t                     w_sat;

  // Beat b covers lanes b*LANES .. b*LANES+LANES-1 of the latched operands
  genvar gi;
  generate
    for (gi = 0; gi < NBEAT; gi++) begin : g_beat
      assign w_w_slices[gi] = r_w[gi*SLICE_W +: SLICE_W];
      assign w_x_slices[gi] = r_x[gi*SLICE_W +: SLICE_W];
    end
  endgenerate

  assign w_w_sel = w_w_slices[r_beat];
  assign w_x_sel = w_x_slices[r_beat];

  mult_add_128_mac_slice #(
    .LANES (LANES)
  ) u_mac_slice (
    .i_w   (w_w_sel),
    .i_x   (w_x_sel),
    .o_sum (w_partial)
  );

  // Arithmetic shift floors toward -inf, so -1 stays -1 after scaling
  assign w_scaled = r_acc >>> SHIFT;
  assign w_sat    = saturate(w_scaled);

  // Next-state and datapath updates; oValid defaults low so it pulses once
  always_comb begin
    w_state_next    = r_state;
    w_beat_next     = r_beat;
    w_acc_next      = r_acc;
    w_w_next        = r_w;
    w_x_next        = r_x;
    w_busy_next     = r_busy;
    w_valid_next    = 1'b0;
    w_result_next   = r_result;
    w_overflow_next = r_overflow;
    case (r_state)
      ST_IDLE: begin
        if (iStart) begin
          w_w_next     = iData1;
          w_x_next     = iData2;
          w_acc_next   = '0;
          w_beat_next  = '0;
          w_busy_next  = 1'b1;
          w_state_next = ST_ACC;
        end
      end
      ST_ACC: begin
        w_acc_next = r_acc + w_partial;
        if (r_beat == LAST_BEAT) begin
          w_beat_next  = '0;
          w_state_next = ST_OUT;
        end else begin
          w_beat_next  = r_beat + BEAT_W'(1);
        end
      end
      ST_OUT: begin
        w_result_next   = w_sat.result;
        w_overflow_next = w_sat.overflow;
        w_valid_next    = 1'b1;
        w_busy_next     = 1'b0;
        w_state_next    = ST_IDLE;
      end
      default: begin
        w_state_next = ST_IDLE;
        w_busy_next  = 1'b0;
      end
    endcase
  end

  // State register; ena low freezes everything, including reset
  always_ff @(posedge clk) begin
    if (ena) begin
      if (!iRst_n) begin
        r_state    <= ST_IDLE;
        r_beat     <= '0;
        r_acc      <= '0;
        r_w        <= '0;
        r_x        <= '0;
        r_busy     <= 1'b0;
        r_valid    <= 1'b0;
        r_result   <= '0;
        r_overflow <= 1'b0;
      end else begin
        r_state    <= w_state_next;
        r_beat     <= w_beat_next;
        r_acc      <= w_acc_next;
        r_w        <= w_w_next;
        r_x        <= w_x_next;
        r_busy     <= w_busy_next;
        r_valid    <= w_valid_next;
        r_result   <= w_result_next;
        r_overflow <= w_overflow_next;
      end
    end
  end

  assign oBusy     = r_busy;
  assign oValid    = r_valid;
  assign oResult   = r_result;
  assign oOverflow = r_overflow;

endmodule

// File: tb/tb_mult_add_128.sv
// Scoreboard bench for mult_add_128: expected results are queued when a
// request is issued and popped when the responder raises oValid.
module tb_mult_add_128;

  logic          clk = 1'b0;
  logic          iRst_n = 1'b0;
  logic          ena = 1'b1;
  logic          iStart = 1'b0;
  logic [1023:0] iData1 = '0;
  logic [1023:0] iData2 = '0;
  logic          oBusy;
  logic          oValid;
  logic [14:0]   oResult;
  logic          oOverflow;

  typedef struct {
    logic [14:0] res;
    logic        ovf;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  mult_add_128 #(.LANES(16)) dut (
    .clk       (clk),
    .iRst_n    (iRst_n),
    .ena       (ena),
    .iStart    (iStart),
    .iData1    (iData1),
    .iData2    (iData2),
    .oBusy     (oBusy),
    .oValid    (oValid),
    .oResult   (oResult),
    .oOverflow (oOverflow)
  );

  always #5 clk = ~clk;

  // Reference: exact integer dot product, floor shift by 7, clamp to 15 bits
  function automatic exp_t model(input logic [1023:0] w, input logic [1023:0] x);
    exp_t       e;
    int         sum;
    int         s;
    int         xi;
    byte signed wb;
    sum = 0;
    for (int i = 0; i < 128; i++) begin
      wb  = w[8*i +: 8];
      xi  = {24'd0, x[8*i +: 8]};
      sum = sum + int'(wb) * xi;
    end
    s = sum >>> 7;
    if (s > 16383) begin
      e.res = 15'h3FFF; e.ovf = 1'b1;
    end else if (s < -16384) begin
      e.res = 15'h4000; e.ovf = 1'b1;
    end else begin
      e.res = s[14:0]; e.ovf = 1'b0;
    end
    return e;
  endfunction

  // Present a request on one edge only, then scramble the data bus
  task automatic issue(input logic [1023:0] w, input logic [1023:0] x);
    iData1 = w;
    iData2 = x;
    iStart = 1'b1;
    @(negedge clk);
    iStart = 1'b0;
    iData1 = ~w;
    iData2 = ~x;
  endtask

  // Count negedges until oValid is seen; cyc starts at the caller's count
  task automatic wait_valid(input int from, output int cyc, output bit to);
    cyc = from;
    to  = 1'b0;
    while (oValid !== 1'b1) begin
      if (cyc >= 60) begin
        to = 1'b1;
        break;
      end
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic test_reset();
    iRst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++; if (oBusy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", oBusy); end
    n_checks++; if (oValid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", oValid); end
    n_checks++; if (oResult !== 15'd0) begin n_fail++; $display("FAIL reset_result: got %h expected 0000", oResult); end
    n_checks++; if (oOverflow !== 1'b0) begin n_fail++; $display("FAIL reset_overflow: got %b expected 0", oOverflow); end
    iRst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_zero_latency();
    int cyc; bit to; exp_t e;
    sb.push_back('{res: 15'd0, ovf: 1'b0});
    issue({128{8'h00}}, {128{8'hFF}});
    n_checks++; if (oBusy !== 1'b1) begin n_fail++; $display("FAIL zero_busy_after_accept: got %b expected 1", oBusy); end
    wait_valid(1, cyc, to);
    n_checks++; if (to || cyc != 10) begin n_fail++; $display("FAIL zero_latency: got %0d cycles (timeout=%b) expected 10", cyc, to); end
    n_checks++; if (oBusy !== 1'b0) begin n_fail++; $display("FAIL zero_busy_at_valid: got %b expected 0", oBusy); end
    e = sb.pop_front();
    n_checks++; if (oResult !== e.res || oOverflow !== e.ovf) begin n_fail++; $display("FAIL zero_result: got %h/%b expected %h/%b", oResult, oOverflow, e.res, e.ovf); end
    $display("txn zero: result=%h ovf=%b cycles=%0d", oResult, oOverflow, cyc);
  endtask

  task automatic test_unity();
    int cyc; bit to; exp_t e;
    sb.push_back('{res: 15'd128, ovf: 1'b0});
    issue({128{8'h01}}, {128{8'h80}});
    wait_valid(1, cyc, to);
    e = sb.pop_front();
    n_checks++; if (to || oResult !== e.res || oOverflow !== e.ovf) begin n_fail++; $display("FAIL unity_result: got %h/%b expected %h/%b", oResult, oOverflow, e.res, e.ovf); end
    $display("txn unity: result=%h ovf=%b cycles=%0d", oResult, oOverflow, cyc);
  endtask

  task automatic test_lane_order();
    int cyc; bit to; exp_t e;
    logic [1023:0] w;
    logic [1023:0] x;
    for (int k = 0; k < 2; k++) begin
      w = '0;
      x = '0;
      if (k == 0) begin
        w[1023:1016] = 8'h02; x[1023:1016] = 8'h80;
      end else begin
        w[7:0] = 8'h02; x[7:0] = 8'h80;
      end
      sb.push_back('{res: 15'd2, ovf: 1'b0});
      issue(w, x);
      wait_valid(1, cyc, to);
      e = sb.pop_front();
      n_checks++; if (to || oResult !== e.res || oOverflow !== e.ovf) begin n_fail++; $display("FAIL lane_order_%0d: got %h/%b expected %h/%b", k, oResult, oOverflow, e.res, e.ovf); end
      $display("txn lane_%0d: result=%h ovf=%b cycles=%0d", (k == 0) ? 127 : 0, oResult, oOverflow, cyc);
    end
  endtask

  task automatic test_saturation();
    int cyc; bit to; exp_t e;
    sb.push_back('{res: 15'h3FFF, ovf: 1'b1});
    issue({128{8'h7F}}, {128{8'hFF}});
    wait_valid(1, cyc, to);
    e = sb.pop_front();
    n_checks++; if (to || oResult !== e.res || oOverflow !== e.ovf) begin n_fail++; $display("FAIL sat_positive: got %h/%b expected %h/%b", oResult, oOverflow, e.res, e.ovf); end
    $display("txn sat_pos: result=%h ovf=%b cycles=%0d", oResult, oOverflow, cyc);
    sb.push_back('{res: 15'h4000, ovf: 1'b1});
    issue({128{8'h80}}, {128{8'hFF}});
    wait_valid(1, cyc, to);
    e = sb.pop_front();
    n_checks++; if (to || oResult !== e.res || oOverflow !== e.ovf) begin n_fail++; $display("FAIL sat_negative: got %h/%b expected %h/%b", oResult, oOverflow, e.res, e.ovf); end
    $display("txn sat_neg: result=%h ovf=%b cycles=%0d", oResult, oOverflow, cyc);
  endtask

  task automatic test_floor();
    int cyc; bit to; exp_t e;
    logic [1023:0] w;
    logic [1023:0] x;
    w = '0; x = '0;
    w[7:0] = 8'hFF; x[7:0] = 8'h01;
    sb.push_back('{res: 15'h7FFF, ovf: 1'b0});
    issue(w, x);
    wait_valid(1, cyc, to);
    e = sb.pop_front();
    n_checks++; if (to || oResult !== e.res || oOverflow !== e.ovf) begin n_fail++; $display("FAIL floor_minus_one: got %h/%b expected %h/%b", oResult, oOverflow, e.res, e.ovf); end
    $display("txn floor: result=%h ovf=%b cycles=%0d", oResult, oOverflow, cyc);
    // Follow a saturating request so a sticky overflow would show up here
    sb.push_back('{res: 15'h3FFF, ovf: 1'b1});
    issue({128{8'h7F}}, {128{8'hFF}});
    wait_valid(1, cyc, to);
    e = sb.pop_front();
    n_checks++; if (to || oResult !== e.res || oOverflow !== e.ovf) begin n_fail++; $display("FAIL floor_sat_setup: got %h/%b expected %h/%b", oResult, oOverflow, e.res, e.ovf); end
    sb.push_back('{res: 15'd128, ovf: 1'b0});
    issue({128{8'h01}}, {128{8'h80}});
    wait_valid(1, cyc, to);
    e = sb.pop_front();
    n_checks++; if (to || oResult !== e.res || oOverflow !== e.ovf) begin n_fail++; $display("FAIL no_stale_overflow: got %h/%b expected %h/%b", oResult, oOverflow, e.res, e.ovf); end
    $display("txn reissue: result=%h ovf=%b cycles=%0d", oResult, oOverflow, cyc);
  endtask

  task automatic test_ignore_start();
    int cyc; bit to; exp_t e;
    sb.push_back('{res: 15'd128, ovf: 1'b0});
    issue({128{8'h01}}, {128{8'h80}});
    repeat (3) @(negedge clk);
    // Second request lands on edge T4 while busy
    iData1 = {128{8'h7F}};
    iData2 = {128{8'hFF}};
    iStart = 1'b1;
    @(negedge clk);
    iStart = 1'b0;
    wait_valid(5, cyc, to);
    n_checks++; if (to || cyc != 10) begin n_fail++; $display("FAIL ignore_latency: got %0d cycles (timeout=%b) expected 10", cyc, to); end
    e = sb.pop_front();
    n_checks++; if (oResult !== e.res || oOverflow !== e.ovf) begin n_fail++; $display("FAIL ignore_result: got %h/%b expected %h/%b", oResult, oOverflow, e.res, e.ovf); end
    $display("txn ignore_start: result=%h ovf=%b cycles=%0d", oResult, oOverflow, cyc);
    @(negedge clk);
    n_checks++; if (oBusy !== 1'b0) begin n_fail++; $display("FAIL ignore_no_queue: got busy=%b expected 0", oBusy); end
  endtask

  task automatic test_reset_abort();
    int cyc; bit to; bit seen; exp_t e;
    issue({128{8'h7F}}, {128{8'hFF}});
    repeat (4) @(negedge clk);
    iRst_n = 1'b0;
    @(negedge clk);
    iRst_n = 1'b1;
    n_checks++; if (oBusy !== 1'b0) begin n_fail++; $display("FAIL abort_busy: got %b expected 0", oBusy); end
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      seen = seen | (oValid === 1'b1);
      @(negedge clk);
    end
    n_checks++; if (seen) begin n_fail++; $display("FAIL abort_valid: got oValid after abort expected none"); end
    sb.push_back('{res: 15'd128, ovf: 1'b0});
    issue({128{8'h01}}, {128{8'h80}});
    wait_valid(1, cyc, to);
    e = sb.pop_front();
    n_checks++; if (to || cyc != 10 || oResult !== e.res || oOverflow !== e.ovf) begin n_fail++; $display("FAIL abort_fresh: got %h/%b in %0d cycles expected %h/%b in 10", oResult, oOverflow, cyc, e.res, e.ovf); end
    $display("txn after_abort: result=%h ovf=%b cycles=%0d", oResult, oOverflow, cyc);
  endtask

  task automatic test_ena_stall();
    int cyc; bit to; exp_t e;
    sb.push_back('{res: 15'd128, ovf: 1'b0});
    issue({128{8'h01}}, {128{8'h80}});
    repeat (2) @(negedge clk);
    ena = 1'b0;
    @(negedge clk);
    iRst_n = 1'b0;  // must be ignored while frozen
    @(negedge clk);
    iRst_n = 1'b1;
    @(negedge clk);
    ena = 1'b1;
    n_checks++; if (oBusy !== 1'b1) begin n_fail++; $display("FAIL stall_busy_held: got %b expected 1", oBusy); end
    wait_valid(6, cyc, to);
    n_checks++; if (to || cyc != 13) begin n_fail++; $display("FAIL stall_latency: got %0d cycles (timeout=%b) expected 13", cyc, to); end
    e = sb.pop_front();
    n_checks++; if (oResult !== e.res || oOverflow !== e.ovf) begin n_fail++; $display("FAIL stall_result: got %h/%b expected %h/%b", oResult, oOverflow, e.res, e.ovf); end
    $display("txn stall: result=%h ovf=%b cycles=%0d", oResult, oOverflow, cyc);
    ena = 1'b0;
    @(negedge clk);
    n_checks++; if (oValid !== 1'b1) begin n_fail++; $display("FAIL frozen_valid_held: got %b expected 1", oValid); end
    ena = 1'b1;
    @(negedge clk);
    n_checks++; if (oValid !== 1'b0) begin n_fail++; $display("FAIL valid_single_pulse: got %b expected 0", oValid); end
  endtask

  task automatic test_back_to_back();
    int cyc; bit to; exp_t e;
    logic [1023:0] w;
    logic [1023:0] x;
    for (int k = 0; k < 4; k++) begin
      for (int j = 0; j < 32; j++) begin
        w[32*j +: 32] = $urandom;
        x[32*j +: 32] = $urandom;
      end
      sb.push_back(model(w, x));
      issue(w, x);
      wait_valid(1, cyc, to);
      e = sb.pop_front();
      n_checks++; if (to || cyc != 10 || oResult !== e.res || oOverflow !== e.ovf) begin n_fail++; $display("FAIL b2b_%0d: got %h/%b in %0d cycles expected %h/%b in 10", k, oResult, oOverflow, cyc, e.res, e.ovf); end
      $display("txn b2b_%0d: result=%h ovf=%b cycles=%0d", k, oResult, oOverflow, cyc);
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_zero_latency();
    test_unity();
    test_lane_order();
    test_saturation();
    test_floor();
    test_ignore_start();
    test_reset_abort();
    test_ena_stall();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
